// File: rtl/accu_arbiter_if.sv
// Core-request / accumulator / RAM bus for accu_arbiter.
// The slave view belongs to the arbiter, and the master view belongs to the cores and RAM side.
interface accu_arbiter_if;
    logic [3:0]  REQ;
    logic [7:0]  REQ_OP;
    logic [31:0] REQ_ARG;
    logic [31:0] REQ_ADDR;
    logic        RAM_VALID;
    logic        ACCUA_WE;
    logic [1:0]  ACCUA_OPCode;
    logic [7:0]  ACCUA_ArgToSet;
    logic        RAM_RE;
    logic [7:0]  RAM_ADDR;
    logic [3:0]  GNT;
    logic [3:0]  ACK;
    logic        ERR;
    logic        BUSY;

    modport slave (
        input  REQ, REQ_OP, REQ_ARG, REQ_ADDR, RAM_VALID,
        output ACCUA_WE, ACCUA_OPCode, ACCUA_ArgToSet, RAM_RE, RAM_ADDR,
               GNT, ACK, ERR, BUSY
    );

    modport master (
        output REQ, REQ_OP, REQ_ARG, REQ_ADDR, RAM_VALID,
        input  ACCUA_WE, ACCUA_OPCode, ACCUA_ArgToSet, RAM_RE, RAM_ADDR,
               GNT, ACK, ERR, BUSY
    );
endinterface

// File: rtl/accu_arbiter.sv
// Round-robin arbiter that lets four cores share one accumulator write port and one RAM read port.
// Outputs are registered when a state is entered, so each output lines up with its state cycle.
module accu_arbiter #(
    parameter int RAM_TIMEOUT = 15
) (
    input  logic           CLK,
    input  logic           RST,
    accu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RAM_WAIT, WRITE} state_t;

    localparam logic [1:0] OP_IMM = 2'b00;
    localparam logic [1:0] OP_RAM = 2'b01;
    localparam logic [1:0] OP_ILL = 2'b11;
    localparam logic [3:0] TMO    = 4'(RAM_TIMEOUT);

    state_t     state;
    logic [1:0] ptr, owner, op_l, sel;
    logic [7:0] arg_l, addr_l;
    logic [3:0] cnt;
    logic       sel_vld, exit_now;

    logic       we_q, re_q, err_q;
    logic [1:0] opc_q;
    logic [7:0] arg_q, raddr_q;
    logic [3:0] gnt_q, ack_q;

    logic [3:0][1:0] op_a;
    logic [3:0][7:0] arg_a, addr_a;
    assign op_a   = bus.REQ_OP;
    assign arg_a  = bus.REQ_ARG;
    assign addr_a = bus.REQ_ADDR;

    // The loop runs from the farthest offset down to the nearest one.
    // The nearest requester at or after ptr is written last, so it wins.
    always_comb begin
        sel     = ptr;
        sel_vld = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.REQ[ptr + 2'(i)]) begin
                sel     = ptr + 2'(i);
                sel_vld = 1'b1;
            end
        end
    end

    // A timeout ACK is raised when the counter steps to TMO.
    // The arbiter leaves in that ACK cycle, so it ignores RAM_VALID there.
    assign exit_now = (state == WRITE) ||
                      (state == ISSUE && op_l == OP_ILL) ||
                      (state == RAM_WAIT && cnt == TMO);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            op_l    <= '0;
            arg_l   <= '0;
            addr_l  <= '0;
            cnt     <= '0;
            we_q    <= 1'b0;
            opc_q   <= '0;
            arg_q   <= '0;
            re_q    <= 1'b0;
            raddr_q <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            we_q    <= 1'b0;
            opc_q   <= '0;
            arg_q   <= '0;
            re_q    <= 1'b0;
            raddr_q <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            case (state)
                IDLE: if (sel_vld) begin
                    state  <= ISSUE;
                    owner  <= sel;
                    op_l   <= op_a[sel];
                    arg_l  <= arg_a[sel];
                    addr_l <= addr_a[sel];
                    gnt_q  <= 4'b0001 << sel;
                    if (op_a[sel] == OP_RAM) begin
                        re_q    <= 1'b1;
                        raddr_q <= addr_a[sel];
                    end
                    if (op_a[sel] == OP_ILL) begin
                        ack_q <= 4'b0001 << sel;
                        err_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                    if (op_l == OP_RAM) begin
                        state <= RAM_WAIT;
                    end else if (op_l != OP_ILL) begin
                        state <= WRITE;
                        we_q  <= 1'b1;
                        opc_q <= op_l;
                        arg_q <= arg_l;
                        ack_q <= gnt_q;
                    end
                end
                RAM_WAIT: if (!exit_now) begin
                    if (bus.RAM_VALID) begin
                        state <= WRITE;
                        we_q  <= 1'b1;
                        opc_q <= op_l;
                        arg_q <= arg_l;
                        ack_q <= gnt_q;
                    end else begin
                        cnt <= cnt + 4'd1;
                        if (cnt + 4'd1 == TMO) begin
                            ack_q <= gnt_q;
                            err_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (exit_now) begin
                state <= IDLE;
                gnt_q <= '0;
                cnt   <= '0;
                ptr   <= owner + 2'd1;
            end
        end
    end

    assign bus.ACCUA_WE       = we_q;
    assign bus.ACCUA_OPCode   = opc_q;
    assign bus.ACCUA_ArgToSet = arg_q;
    assign bus.RAM_RE         = re_q;
    assign bus.RAM_ADDR       = raddr_q;
    assign bus.GNT            = gnt_q;
    assign bus.ACK            = ack_q;
    assign bus.ERR            = err_q;
    assign bus.BUSY           = (state != IDLE);
endmodule

// File: tb/tb_accu_arbiter.sv
// Directed testbench for accu_arbiter.
// Each cycle, the full output vector is compared with a hand-built expected value.
module tb_accu_arbiter;
    logic CLK, RST;
    accu_arbiter_if bus();

    accu_arbiter #(.RAM_TIMEOUT(15)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int fails  = 0;
    logic [29:0] exp_v;

    // Field order: WE, OPC, ARG, RE, RADDR, GNT, ACK, ERR, BUSY
    function automatic logic [29:0] outs();
        return {bus.ACCUA_WE, bus.ACCUA_OPCode, bus.ACCUA_ArgToSet, bus.RAM_RE,
                bus.RAM_ADDR, bus.GNT, bus.ACK, bus.ERR, bus.BUSY};
    endfunction

    function automatic logic [29:0] ov(logic we, logic [1:0] opc, logic [7:0] arg, logic re,
                                       logic [7:0] ra, logic [3:0] gnt, logic [3:0] ack,
                                       logic err, logic busy);
        return {we, opc, arg, re, ra, gnt, ack, err, busy};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_core(int c, logic [1:0] op, logic [7:0] arg, logic [7:0] addr);
        bus.REQ_OP[2*c +: 2]   = op;
        bus.REQ_ARG[8*c +: 8]  = arg;
        bus.REQ_ADDR[8*c +: 8] = addr;
    endtask

    // The task returns in the first cycle after reset release, which is cycle 0.
    task automatic do_reset();
        RST = 1'b1;
        bus.REQ = '0; bus.REQ_OP = '0; bus.REQ_ARG = '0; bus.REQ_ADDR = '0;
        bus.RAM_VALID = 1'b0;
        step();
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (outs() !== 30'h0) begin
            fails++;
            $display("FAIL reset_outs got=%h exp=%h", outs(), 30'h0);
        end
    endtask

    // Core 2 sets an immediate directly out of reset.
    // Its argument is changed after the latch, and the change must be ignored.
    task automatic test_set_imm();
        do_reset();
        set_core(2, 2'b00, 8'h5A, 8'h00);
        bus.REQ = 4'b0100;
        exp_v = '0;
        checks++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL imm_c0 got=%h exp=%h", outs(), exp_v);
        end
        step();
        set_core(2, 2'b10, 8'hFF, 8'h00);
        exp_v = ov(0, 2'b00, 8'h00, 0, 8'h00, 4'b0100, 4'b0000, 0, 1);
        checks++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL imm_c1 got=%h exp=%h", outs(), exp_v);
        end
        step();
        exp_v = ov(1, 2'b00, 8'h5A, 0, 8'h00, 4'b0100, 4'b0100, 0, 1);
        checks++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL imm_c2 got=%h exp=%h", outs(), exp_v);
        end
        bus.REQ = 4'b0000;
        step();
        checks++;
        if (outs() !== 30'h0) begin
            fails++;
            $display("FAIL imm_c3 got=%h exp=%h", outs(), 30'h0);
        end
    endtask

    // Core 0 loads an ALU result (op 10) while PTR still points at core 3.
    task automatic test_alu_load();
        set_core(0, 2'b10, 8'h11, 8'h00);
        bus.REQ = 4'b0001;
        step();
        step();
        exp_v = ov(1, 2'b10, 8'h11, 0, 8'h00, 4'b0001, 4'b0001, 0, 1);
        checks++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL alu_c2 got=%h exp=%h", outs(), exp_v);
        end
        bus.REQ = 4'b0000;
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0] g;
        do_reset();
        for (int c = 0; c < 4; c++) set_core(c, 2'b00, 8'h10 + 8'(c), 8'h00);
        bus.REQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            g = 4'b0001 << (k % 4);
            step();
            exp_v = ov(0, 2'b00, 8'h00, 0, 8'h00, g, 4'b0000, 0, 1);
            checks++;
            if (outs() !== exp_v) begin
                fails++;
                $display("FAIL rr_issue%0d got=%h exp=%h", k, outs(), exp_v);
            end
            step();
            exp_v = ov(1, 2'b00, 8'h10 + 8'(k % 4), 0, 8'h00, g, g, 0, 1);
            checks++;
            if (outs() !== exp_v) begin
                fails++;
                $display("FAIL rr_write%0d got=%h exp=%h", k, outs(), exp_v);
            end
            step();
            checks++;
            if (outs() !== 30'h0) begin
                fails++;
                $display("FAIL rr_idle%0d got=%h exp=%h", k, outs(), 30'h0);
            end
        end
    endtask

    // A RAM_VALID that arrives while the arbiter is in IDLE must be ignored.
    task automatic test_ram_load();
        do_reset();
        set_core(1, 2'b01, 8'h77, 8'h33);
        bus.REQ = 4'b0010;
        bus.RAM_VALID = 1'b1;
        step();
        bus.RAM_VALID = 1'b0;
        exp_v = ov(0, 2'b00, 8'h00, 1, 8'h33, 4'b0010, 4'b0000, 0, 1);
        checks++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL ram_c1 got=%h exp=%h", outs(), exp_v);
        end
        for (int c = 2; c <= 5; c++) begin
            step();
            if (c == 5) bus.RAM_VALID = 1'b1;
            exp_v = ov(0, 2'b00, 8'h00, 0, 8'h00, 4'b0010, 4'b0000, 0, 1);
            checks++;
            if (outs() !== exp_v) begin
                fails++;
                $display("FAIL ram_wait_c%0d got=%h exp=%h", c, outs(), exp_v);
            end
        end
        step();
        bus.RAM_VALID = 1'b0;
        bus.REQ = 4'b0000;
        exp_v = ov(1, 2'b01, 8'h77, 0, 8'h00, 4'b0010, 4'b0010, 0, 1);
        checks++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL ram_c6 got=%h exp=%h", outs(), exp_v);
        end
        step();
        checks++;
        if (outs() !== 30'h0) begin
            fails++;
            $display("FAIL ram_c7 got=%h exp=%h", outs(), 30'h0);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        set_core(0, 2'b01, 8'h00, 8'hC4);
        bus.REQ = 4'b0001;
        step();
        exp_v = ov(0, 2'b00, 8'h00, 1, 8'hC4, 4'b0001, 4'b0000, 0, 1);
        checks++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL tmo_c1 got=%h exp=%h", outs(), exp_v);
        end
        for (int c = 2; c <= 16; c++) begin
            step();
            exp_v = ov(0, 2'b00, 8'h00, 0, 8'h00, 4'b0001, 4'b0000, 0, 1);
            checks++;
            if (outs() !== exp_v) begin
                fails++;
                $display("FAIL tmo_wait_c%0d got=%h exp=%h", c, outs(), exp_v);
            end
        end
        step();
        bus.REQ = 4'b0000;
        exp_v = ov(0, 2'b00, 8'h00, 0, 8'h00, 4'b0001, 4'b0001, 1, 1);
        checks++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL tmo_ack got=%h exp=%h", outs(), exp_v);
        end
        step();
        checks++;
        if (outs() !== 30'h0) begin
            fails++;
            $display("FAIL tmo_after got=%h exp=%h", outs(), 30'h0);
        end
    endtask

    // Illegal op from core 3. The pointer should wrap to 0, so core 0 then wins over core 3.
    task automatic test_illegal();
        do_reset();
        set_core(3, 2'b11, 8'hAA, 8'h00);
        bus.REQ = 4'b1000;
        step();
        set_core(3, 2'b00, 8'h03, 8'h00);
        set_core(0, 2'b00, 8'h0C, 8'h00);
        bus.REQ = 4'b1001;
        exp_v = ov(0, 2'b00, 8'h00, 0, 8'h00, 4'b1000, 4'b1000, 1, 1);
        checks++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL ill_c1 got=%h exp=%h", outs(), exp_v);
        end
        step();
        checks++;
        if (outs() !== 30'h0) begin
            fails++;
            $display("FAIL ill_c2 got=%h exp=%h", outs(), 30'h0);
        end
        step();
        exp_v = ov(0, 2'b00, 8'h00, 0, 8'h00, 4'b0001, 4'b0000, 0, 1);
        checks++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL ill_ptr got=%h exp=%h", outs(), exp_v);
        end
        step();
        bus.REQ = 4'b1000;
        step();
    endtask

    task automatic test_rst_mid();
        do_reset();
        set_core(2, 2'b01, 8'h22, 8'h44);
        bus.REQ = 4'b0100;
        step();
        step();
        exp_v = ov(0, 2'b00, 8'h00, 0, 8'h00, 4'b0100, 4'b0000, 0, 1);
        checks++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL rstm_wait got=%h exp=%h", outs(), exp_v);
        end
        RST = 1'b1;
        bus.RAM_VALID = 1'b1;
        step();
        RST = 1'b0;
        bus.RAM_VALID = 1'b0;
        set_core(0, 2'b00, 8'h99, 8'h00);
        bus.REQ = 4'b0101;
        checks++;
        if (outs() !== 30'h0) begin
            fails++;
            $display("FAIL rstm_clear got=%h exp=%h", outs(), 30'h0);
        end
        step();
        exp_v = ov(0, 2'b00, 8'h00, 0, 8'h00, 4'b0001, 4'b0000, 0, 1);
        checks++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL rstm_gnt got=%h exp=%h", outs(), exp_v);
        end
        step();
        exp_v = ov(1, 2'b00, 8'h99, 0, 8'h00, 4'b0001, 4'b0001, 0, 1);
        checks++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL rstm_write got=%h exp=%h", outs(), exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_set_imm();
        test_alu_load();
        test_back_to_back();
        test_ram_load();
        test_timeout();
        test_illegal();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
